// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that reuses one digit cell.
// Digits are added LSD first, one per clock, with the carry rippling in a register.
module bcd_serial_add_ctrl #(
    parameter int NDIG = 4,
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t            state;
    logic [4*NDIG-1:0] ar;
    logic [4*NDIG-1:0] br;
    logic              carry;
    logic [IW-1:0]     idx;

    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] bin;
    logic       dc;
    logic [3:0] digit;
    logic       bad;
    logic       last;

    always_comb begin
        x     = ar[4*int'(idx) +: 4];
        y     = br[4*int'(idx) +: 4];
        bin   = {1'b0, x} + {1'b0, y} + {4'b0, carry};
        dc    = bin[4] | (bin[3] & bin[2]) | (bin[3] & bin[1]);
        digit = bin[3:0] + {1'b0, dc, dc, 1'b0};
        last  = (idx == IW'(NDIG - 1));
    end

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            ar    <= '0;
            br    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        ar    <= a;
                        br    <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        err   <= bad;
                        busy  <= 1'b1;
                        state <= ADD;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ADD: begin
                    sum[4*int'(idx) +: 4] <= digit;
                    carry <= dc;
                    if (last) begin
                        // idx parks at 0 so the cell never indexes past the operand
                        idx   <= '0;
                        cout  <= dc;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: decimal-level model checked every cycle,
// plus directed literal checks on a 4-digit and a 1-digit instance.
module tb_bcd_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, cin4;
    logic [15:0] a4, b4;
    logic        busy4, done4, cout4, err4;
    logic [15:0] sum4;
    logic        start1, cin1;
    logic [3:0]  a1, b1;
    logic        busy1, done1, cout1, err1;
    logic [3:0]  sum1;

    int vecs = 0;
    int miss = 0;
    bit chk = 1'b0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.NDIG(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .err(err4)
    );

    bcd_serial_add_ctrl #(.NDIG(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
    );

    // Digit-by-digit decimal addition; a raw digit sum above 9 wraps by +6.
    function automatic logic [16:0] model_add(input logic [15:0] x,
                                              input logic [15:0] y,
                                              input logic c);
        logic [15:0] r;
        logic        cc;
        int          s;
        r  = '0;
        cc = c;
        for (int i = 0; i < 4; i++) begin
            s = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + int'(cc);
            if (s > 9) begin
                r[4*i +: 4] = 4'((s + 6) % 16);
                cc = 1'b1;
            end else begin
                r[4*i +: 4] = 4'(s);
                cc = 1'b0;
            end
        end
        return {cc, r};
    endfunction

    function automatic logic model_err(input logic [15:0] x, input logic [15:0] y);
        logic e;
        e = 1'b0;
        for (int i = 0; i < 4; i++)
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) e = 1'b1;
        return e;
    endfunction

    int          m_cnt;
    logic        m_done, m_err, m_cout, p_cout;
    logic [15:0] m_sum, p_sum;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
            m_cout <= 1'b0;
            m_sum  <= '0;
            p_sum  <= '0;
            p_cout <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) begin
                m_sum  <= p_sum;
                m_cout <= p_cout;
            end
        end else begin
            m_done <= 1'b0;
            if (start4) begin
                m_cnt  <= 4;
                {p_cout, p_sum} <= model_add(a4, b4, cin4);
                m_err  <= model_err(a4, b4);
                m_sum  <= '0;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cmp("model busy", 32'(busy4), 32'(m_cnt != 0));
            cmp("model done", 32'(done4), 32'(m_done));
            cmp("model err", 32'(err4), 32'(m_err));
            if (m_cnt == 0) begin
                cmp("model sum", 32'(sum4), 32'(m_sum));
                cmp("model cout", 32'(cout4), 32'(m_cout));
            end
        end
    end

    task automatic pulse4(input logic [15:0] x, input logic [15:0] y, input logic c);
        @(posedge clk); #2;
        start4 = 1'b1; a4 = x; b4 = y; cin4 = c;
        @(posedge clk); #2;
        start4 = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [15:0] es,
                             input logic ec, input logic ee, output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (done4) seen = 1'b1;
            else if (busy4) nbusy++;
        end
        if (!seen) begin
            vecs++;
            miss++;
            $display("FAIL %s timeout: no done within 20 cycles", name);
        end else begin
            cmp({name, " sum"}, 32'(sum4), 32'(es));
            cmp({name, " cout"}, 32'(cout4), 32'(ec));
            cmp({name, " err"}, 32'(err4), 32'(ee));
        end
    endtask

    int nb;

    initial begin
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #12;
        cmp("reset busy", 32'(busy4), 32'd0);
        cmp("reset done", 32'(done4), 32'd0);
        cmp("reset sum", 32'(sum4), 32'd0);
        rst = 1'b0;
        chk = 1'b1;

        pulse4(16'h1234, 16'h5678, 1'b0);
        wait_done("t1", 16'h6912, 1'b0, 1'b0, nb);
        cmp("t1 busy cycles", 32'(nb), 32'd4);

        pulse4(16'h9999, 16'h0001, 1'b0);
        wait_done("t2a", 16'h0000, 1'b1, 1'b0, nb);
        pulse4(16'h9999, 16'h9999, 1'b1);
        wait_done("t2b", 16'h9999, 1'b1, 1'b0, nb);

        // start held through the op; second request is taken in the DONE cycle
        @(posedge clk); #2;
        start4 = 1'b1; a4 = 16'h1234; b4 = 16'h5678; cin4 = 1'b0;
        @(posedge clk); #2;
        a4 = 16'h0099; b4 = 16'h0001;
        wait_done("t3a", 16'h6912, 1'b0, 1'b0, nb);
        wait_done("t3b", 16'h0100, 1'b0, 1'b0, nb);
        cmp("t3 b2b busy cycles", 32'(nb), 32'd4);
        start4 = 1'b0;
        @(posedge clk); @(posedge clk);

        pulse4(16'h4321, 16'h1111, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        cmp("t4 rst busy", 32'(busy4), 32'd0);
        cmp("t4 rst sum", 32'(sum4), 32'd0);
        cmp("t4 rst cout", 32'(cout4), 32'd0);
        cmp("t4 rst err", 32'(err4), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmp("t4 no done", 32'(done4), 32'd0);
        end
        pulse4(16'h0458, 16'h0542, 1'b0);
        wait_done("t4 after", 16'h1000, 1'b0, 1'b0, nb);

        pulse4(16'h000A, 16'h0000, 1'b0);
        wait_done("t5 bad", 16'h0010, 1'b0, 1'b1, nb);
        pulse4(16'h0001, 16'h0002, 1'b0);
        wait_done("t5 clear", 16'h0003, 1'b0, 1'b0, nb);

        @(posedge clk); #2;
        start1 = 1'b1; a1 = 4'h7; b1 = 4'h5; cin1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        cmp("t6 busy", 32'(busy1), 32'd1);
        cmp("t6 early done", 32'(done1), 32'd0);
        @(posedge clk); #2;
        cmp("t6 done", 32'(done1), 32'd1);
        cmp("t6 sum", 32'(sum1), 32'h3);
        cmp("t6 cout", 32'(cout1), 32'd1);
        cmp("t6 err", 32'(err1), 32'd0);
        @(posedge clk); #2;
        cmp("t6 done drop", 32'(done1), 32'd0);
        cmp("t6 sum held", 32'(sum1), 32'h3);

        @(posedge clk);
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
